// File: rtl/dm_pkg.sv
// Shared definitions for the dm_sized data memory.
//   - access size encodings carried on the size port
//   - scrub/idle FSM state type
//   - load metadata held between the array read and the extend stage
package dm_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } dm_state_t;

    typedef struct packed {
        logic [1:0] size;  // normalised size (never SZ_ILL)
        logic [1:0] off;   // byte offset of the lowest selected lane
        logic       uns;   // zero-extend when set
    } ld_meta_t;

    // The illegal encoding behaves as a word access wherever it is not rejected.
    function automatic logic [1:0] norm_size(input logic [1:0] s);
        return (s == SZ_ILL) ? SZ_WORD : s;
    endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Combinational lane steering for dm_sized.
// Store side:
//   size, off, din  -> misalign flag, effective size/offset, byte enables,
//                      lane-replicated write data
// Load side:
//   ld_meta, rd_word -> ld_data (selected lanes shifted to bit 0, extended)
// The effective offset has the bits below the access size cleared, so an
// unchecked misaligned access lands on the aligned lanes.
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] din,
    output logic        misalign,
    output logic [1:0]  eff_size,
    output logic [1:0]  eff_off,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    input  ld_meta_t    ld_meta,
    input  logic [31:0] rd_word,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;
    logic        fill;

    always_comb begin
        // NOTE: every output gets a default before the case, so no path leaves one unassigned and no latch is inferred.
        misalign = 1'b0;
        eff_size = norm_size(size);
        eff_off  = off;
        be       = 4'b0000;
        wdata    = din;
        case (eff_size)
            SZ_BYTE: begin
                be    = 4'b0001 << off;
                wdata = {4{din[7:0]}};
            end
            SZ_HALF: begin
                misalign = off[0];
                eff_off  = {off[1], 1'b0};
                be       = off[1] ? 4'b1100 : 4'b0011;
                wdata    = {2{din[15:0]}};
            end
            default: begin
                misalign = (size == SZ_ILL) || (off != 2'b00);
                eff_off  = 2'b00;
                be       = 4'b1111;
                wdata    = din;
            end
        endcase
    end

    always_comb begin
        shifted = rd_word >> {ld_meta.off, 3'b000};
        fill    = 1'b0;
        ld_data = rd_word;
        case (ld_meta.size)
            SZ_BYTE: begin
                fill    = ~ld_meta.uns & shifted[7];
                ld_data = {{24{fill}}, shifted[7:0]};
            end
            SZ_HALF: begin
                fill    = ~ld_meta.uns & shifted[15];
                ld_data = {{16{fill}}, shifted[15:0]};
            end
            default: ld_data = rd_word;
        endcase
    end

endmodule

// File: rtl/dm_sized.sv
// dm_sized: single-port MIPS32 data memory with byte/half/word access and a
// one-word-per-cycle scrub sequencer started by clr.
// Parameters: ADDR_W (word-address bits, depth 2^ADDR_W), CLR_VAL (scrub value)
// Ports:
//   clk, clr (sync active-high reset, starts scrub)
//   req, we, size, uns, addr, din  : access request
//   ready                          : access can be accepted (low while scrubbing)
//   rvalid, rdata                  : load result, one cycle after the read
//   err                            : pulse for a rejected misaligned access
// Build option: define DM_ALIGN_CHECK_EN to reject misaligned / size=11
// accesses with an err pulse; otherwise they are forced aligned and err is 0.
module dm_sized
    import dm_pkg::*;
#(
    parameter int          ADDR_W  = 10,
    parameter logic [31:0] CLR_VAL = 32'h0
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    output logic        ready,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int DEPTH = 1 << ADDR_W;

    dm_state_t         state, state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic              scrub_we;

    logic [ADDR_W-1:0] widx;
    logic              accept, reject, do_store, do_load;
    logic              misalign;
    logic [1:0]        eff_size, eff_off;
    logic [3:0]        st_be;
    logic [31:0]       st_wdata, ld_data;

    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_idx;
    logic [31:0]       mem_wdata;
    logic [3:0][7:0]   mem [DEPTH];
    logic [31:0]       rd_word;
    ld_meta_t          ld_meta;
    logic              ld_pend;

    logic              unused_addr_hi;
    assign unused_addr_hi = ^addr[31:ADDR_W+2];

    assign widx = addr[ADDR_W+1:2];

    // ---------------- FSM ----------------
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clr) state <= CLEAR;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (ptr == '1) state_nxt = IDLE;
            IDLE:    state_nxt = IDLE;
            default: state_nxt = CLEAR;
        endcase
    end

    always_comb begin
        ready    = 1'b0;
        scrub_we = 1'b0;
        case (state)
            CLEAR:   scrub_we = 1'b1;
            IDLE:    ready    = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr)                ptr <= '0;
        else if (state == CLEAR) ptr <= ptr + ADDR_W'(1);
    end

    // ---------------- access decode ----------------
    dm_lane_align u_align (
        .size     (size),
        .off      (addr[1:0]),
        .din      (din),
        .misalign (misalign),
        .eff_size (eff_size),
        .eff_off  (eff_off),
        .be       (st_be),
        .wdata    (st_wdata),
        .ld_meta  (ld_meta),
        .rd_word  (rd_word),
        .ld_data  (ld_data)
    );

    // clr wins over a request presented on the same edge.
    assign accept   = req & ready & ~clr;
    assign do_store = accept &  we & ~reject;
    assign do_load  = accept & ~we & ~reject;

`ifdef DM_ALIGN_CHECK_EN
    logic err_pend, err_q;

    assign reject = accept & misalign;
    assign err    = err_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            err_pend <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_pend <= reject;
            err_q    <= err_pend;
        end
    end
`else
    logic unused_misalign;

    assign unused_misalign = misalign;
    assign reject          = 1'b0;
    assign err             = 1'b0;
`endif

    // ---------------- single array port ----------------
    always_comb begin
        mem_we    = 1'b0;
        mem_be    = 4'b1111;
        mem_idx   = widx;
        mem_wdata = CLR_VAL;
        if (scrub_we && !clr) begin
            mem_we  = 1'b1;
            mem_idx = ptr;
        end else if (do_store) begin
            mem_we    = 1'b1;
            mem_be    = st_be;
            mem_wdata = st_wdata;
        end
    end

    // NOTE: the array has no reset branch; the scrub sequencer clears it, which keeps it mappable to block RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (mem_be[k]) mem[mem_idx][k] <= mem_wdata[8*k +: 8];
            end
        end
        if (do_load) begin
            rd_word <= mem[mem_idx];
            ld_meta <= '{size: eff_size, off: eff_off, uns: uns};
        end
    end

    // ---------------- load result pipeline ----------------
    // Read at the accept edge, extend and publish on the following edge.
    always_ff @(posedge clk) begin
        if (clr) begin
            ld_pend <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
        end else begin
            ld_pend <= do_load;
            rvalid  <= ld_pend;
            if (ld_pend) rdata <= ld_data;
        end
    end

endmodule

// File: tb/tb_dm_sized.sv
module tb_dm_sized;
    import dm_pkg::*;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        uns = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] din = '0;
    logic        ready, rvalid, err;
    logic [31:0] rdata;

    dm_sized dut (
        .clk    (clk),
        .clr    (clr),
        .req    (req),
        .we     (we),
        .size   (size),
        .uns    (uns),
        .addr   (addr),
        .din    (din),
        .ready  (ready),
        .rvalid (rvalid),
        .rdata  (rdata),
        .err    (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] din;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [1:0] s, input logic u,
                         input logic [31:0] a, input logic [31:0] d);
        req  = 1'b1;
        we   = w;
        size = s;
        uns  = u;
        addr = a;
        din  = d;
    endtask

    task automatic idle_in();
        req = 1'b0;
        we  = 1'b0;
    endtask

    task automatic load_check(input string name, input logic [1:0] s, input logic u,
                              input logic [31:0] a, input logic [31:0] exp);
        drive(1'b0, s, u, a, 32'h0);
        tick();
        idle_in();
        tick();
        check({name, " rvalid"}, {31'b0, rvalid}, 32'h1);
        check({name, " rdata"}, rdata, exp);
    endtask

    // Counts edges after the clr edge until ready is seen high.
    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 2000) begin
            tick();
            n++;
        end
    endtask

    function automatic void add(input string nm, input logic w, input logic [1:0] s,
                                input logic u, input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] exp, input logic e);
        vecs.push_back('{name: nm, we: w, size: s, uns: u, addr: a, din: d,
                         exp_rdata: exp, exp_err: e});
    endfunction

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int          n;
        logic        exp_rv;
        logic [31:0] exp_d;
        int          pairs;

        // ---------- reset and first scrub ----------
        tick();
        clr = 1'b0;
        check("reset ready", {31'b0, ready}, 32'h0);
        check("reset rvalid", {31'b0, rvalid}, 32'h0);
        check("reset rdata", rdata, 32'h0);
        check("reset err", {31'b0, err}, 32'h0);
        wait_ready(n);
        check("scrub length", n, 1024);
        check("scrub rvalid quiet", {31'b0, rvalid}, 32'h0);
        load_check("load word 1023", SZ_WORD, 1'b0, 32'h0000_0FFC, 32'h0);

        // ---------- table-driven vectors ----------
        add("st word 0x10",   1, SZ_WORD, 0, 32'h10, 32'h1122_3344, 32'h0, 0);
        add("st byte 0x12",   1, SZ_BYTE, 0, 32'h12, 32'h0000_00AA, 32'h0, 0);
        add("ld word 0x10",   0, SZ_WORD, 0, 32'h10, 32'h0, 32'h11AA_3344, 0);
        add("ld half s 0x12", 0, SZ_HALF, 0, 32'h12, 32'h0, 32'h0000_11AA, 0);
        add("ld byte s 0x12", 0, SZ_BYTE, 0, 32'h12, 32'h0, 32'hFFFF_FFAA, 0);
        add("ld byte u 0x12", 0, SZ_BYTE, 1, 32'h12, 32'h0, 32'h0000_00AA, 0);
        add("ld byte s 0x13", 0, SZ_BYTE, 0, 32'h13, 32'h0, 32'h0000_0011, 0);
        add("ld byte s 0x10", 0, SZ_BYTE, 0, 32'h10, 32'h0, 32'h0000_0044, 0);
        add("st half 0x16",   1, SZ_HALF, 0, 32'h16, 32'h1234_8001, 32'h0, 0);
        add("ld word 0x14",   0, SZ_WORD, 0, 32'h14, 32'h0, 32'h8001_0000, 0);
        add("ld half s 0x16", 0, SZ_HALF, 0, 32'h16, 32'h0, 32'hFFFF_8001, 0);
        add("ld half u 0x16", 0, SZ_HALF, 1, 32'h16, 32'h0, 32'h0000_8001, 0);
        add("ld half s 0x14", 0, SZ_HALF, 0, 32'h14, 32'h0, 32'h0000_0000, 0);
        add("ld word u 0x10", 0, SZ_WORD, 1, 32'h10, 32'h0, 32'h11AA_3344, 0);
        add("ld word hi addr",0, SZ_WORD, 0, 32'h0001_0010, 32'h0, 32'h11AA_3344, 0);
        add("st byte 0x15",   1, SZ_BYTE, 0, 32'h15, 32'hFFFF_FF5A, 32'h0, 0);
        add("ld word 0x14 b", 0, SZ_WORD, 0, 32'h14, 32'h0, 32'h8001_5A00, 0);
`ifdef DM_ALIGN_CHECK_EN
        add("st half 0x21 mis", 1, SZ_HALF, 0, 32'h21, 32'h0000_BEEF, 32'h0, 1);
        add("ld word 0x20",     0, SZ_WORD, 0, 32'h20, 32'h0, 32'h0000_0000, 0);
        add("ld half 0x13 mis", 0, SZ_HALF, 0, 32'h13, 32'h0, 32'h0, 1);
        add("ld size11 0x12",   0, SZ_ILL,  0, 32'h12, 32'h0, 32'h0, 1);
        add("ld word 0x17 mis", 0, SZ_WORD, 0, 32'h17, 32'h0, 32'h0, 1);
        add("ld size11 0x10",   0, SZ_ILL,  0, 32'h10, 32'h0, 32'h0, 1);
`else
        add("st half 0x21 mis", 1, SZ_HALF, 0, 32'h21, 32'h0000_BEEF, 32'h0, 0);
        add("ld word 0x20",     0, SZ_WORD, 0, 32'h20, 32'h0, 32'h0000_BEEF, 0);
        add("ld half 0x13 mis", 0, SZ_HALF, 0, 32'h13, 32'h0, 32'h0000_11AA, 0);
        add("ld size11 0x12",   0, SZ_ILL,  0, 32'h12, 32'h0, 32'h11AA_3344, 0);
        add("ld word 0x17 mis", 0, SZ_WORD, 0, 32'h17, 32'h0, 32'h8001_5A00, 0);
        add("ld size11 0x10",   0, SZ_ILL,  0, 32'h10, 32'h0, 32'h11AA_3344, 0);
`endif

        foreach (vecs[i]) begin
            drive(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].din);
            tick();
            idle_in();
            check({vecs[i].name, " rvalid early"}, {31'b0, rvalid}, 32'h0);
            tick();
            exp_rv = !vecs[i].we && !vecs[i].exp_err;
            check({vecs[i].name, " rvalid"}, {31'b0, rvalid}, {31'b0, exp_rv});
            if (exp_rv) check({vecs[i].name, " rdata"}, rdata, vecs[i].exp_rdata);
            check({vecs[i].name, " err"}, {31'b0, err}, {31'b0, vecs[i].exp_err});
        end

        // ---------- back-to-back store/load stream ----------
        pairs = 6;
        for (int c = 0; c < 2 * pairs + 2; c++) begin
            if (c < 2 * pairs) begin
                if (c % 2 == 0)
                    drive(1'b1, SZ_WORD, 1'b0, 32'h20 + 32'(4 * (c / 2)), {8'hA5, 16'h0, 8'(c / 2)});
                else
                    drive(1'b0, SZ_WORD, 1'b0, 32'h20 + 32'(4 * (c / 2)), 32'h0);
            end else begin
                idle_in();
            end
            tick();
            exp_rv = (c >= 2) && (c % 2 == 0) && (c <= 2 * pairs);
            check($sformatf("stream c%0d rvalid", c), {31'b0, rvalid}, {31'b0, exp_rv});
            if (exp_rv) begin
                exp_d = {8'hA5, 16'h0, 8'((c - 2) / 2)};
                check($sformatf("stream c%0d rdata", c), rdata, exp_d);
            end
            check($sformatf("stream c%0d ready", c), {31'b0, ready}, 32'h1);
        end

        // ---------- clr with a load in flight ----------
        drive(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
        tick();
        idle_in();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr inflight rvalid", {31'b0, rvalid}, 32'h0);
        check("clr inflight rdata", rdata, 32'h0);
        check("clr inflight ready", {31'b0, ready}, 32'h0);

        // ---------- clr mid-scrub restarts the count ----------
        for (int c = 0; c < 499; c++) tick();
        check("mid scrub ready", {31'b0, ready}, 32'h0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        // A store held during the scrub must be ignored.
        drive(1'b1, SZ_WORD, 1'b0, 32'h0, 32'hDEAD_BEEF);
        wait_ready(n);
        idle_in();
        check("restart scrub length", n, 1024);
        load_check("post scrub word 0x10", SZ_WORD, 1'b0, 32'h10, 32'h0);
        load_check("ignored store word 0", SZ_WORD, 1'b0, 32'h0, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
